ibis_blit_scheduler: RTL and testbench

Sequences ibis_blitter. Accepts blit descriptors (src, dst, width, height) from NUM_REQ requesters and grants one at a time, round-robin. Drives the blitter's configuration and enable, and walks x/y over the clipped destination rectangle at one pixel per cycle. Waits out the blitter's 5-stage pipeline, then reports completion.

---
 rtl/ibis_blit_pkg.sv | 30 +++
 rtl/ibis_blit_scheduler_if.sv | 26 ++
 rtl/ibis_rr_arbiter.sv | 60 ++++++
 rtl/ibis_blit_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_ibis_blit_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibis_blit_pkg.sv
// Shared types for the ibis blitter scheduler.
// Descriptor layout, FSM states, blitter latency, index-width helper.
package ibis_blit_pkg;

  localparam int BLIT_W = 10;
  localparam int IBIS_BLITTER_PIPE_DEPTH = 5;

  // First member is MSB: src_x sits at bit 0.
  typedef struct packed {
    logic [BLIT_W-1:0] height;
    logic [BLIT_W-1:0] width;
    logic [BLIT_W-1:0] dst_y;
    logic [BLIT_W-1:0] dst_x;
    logic [BLIT_W-1:0] src_y;
    logic [BLIT_W-1:0] src_x;
  } blit_desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ibis_blit_scheduler_if.sv
// Requester-side descriptor handshake bundle.
// req_valid/req_desc from requesters, req_ready back (one-hot or zero).
interface ibis_blit_scheduler_if
  import ibis_blit_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = BLIT_W
);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*6*WIDTH-1:0] req_desc;

  modport master (
    output req_valid,
    output req_desc,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_desc,
    output req_ready
  );

endinterface

// File: rtl/ibis_rr_arbiter.sv
// Round-robin arbiter: grants first req at/after ptr.
// Ports: clk, rst_n, req, advance -> gnt (one-hot), gnt_idx.
module ibis_rr_arbiter
  import ibis_blit_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic                        advance,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [idx_w(NUM_REQ)-1:0]   gnt_idx
);

  localparam int IW = idx_w(NUM_REQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] sel_hi;
  logic [IW-1:0] sel_lo;
  logic          any_hi;

  // Descending scan leaves the lowest match in each selector.
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    any_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) >= ptr)) begin
        sel_hi = IW'(i);
        any_hi = 1'b1;
      end
      if (req[i]) begin
        sel_lo = IW'(i);
      end
    end
  end

  assign gnt_idx = any_hi ? sel_hi : sel_lo;

  always_comb begin
    gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = (|req) && (gnt_idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      if (gnt_idx == IW'(NUM_REQ - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ibis_blit_scheduler.sv
// Blit scheduler: RR grant, clip, raster scan, drain, done pulse.
// Ports: aclk/aresetn, req (slave if), blt_* config/scan, busy, done,
// done_id, pixel_count; IBIS_BLIT_SCHED_ABORT_EN adds abort/aborted.
module ibis_blit_scheduler
  import ibis_blit_pkg::*;
#(
  parameter int WIDTH      = BLIT_W,
  parameter int X_MAX      = 640,
  parameter int Y_MAX      = 480,
  parameter int NUM_REQ    = 2,
  parameter int PIPE_DEPTH = IBIS_BLITTER_PIPE_DEPTH
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  ibis_blit_scheduler_if.slave      req,
  output logic                      blt_enable,
  output logic [WIDTH-1:0]          blt_x,
  output logic [WIDTH-1:0]          blt_y,
  output logic [WIDTH-1:0]          blt_x_src,
  output logic [WIDTH-1:0]          blt_y_src,
  output logic [WIDTH-1:0]          blt_x_dst,
  output logic [WIDTH-1:0]          blt_y_dst,
  output logic [WIDTH-1:0]          blt_width,
  output logic [WIDTH-1:0]          blt_height,
  input  logic                      blt_out_valid,
  output logic                      busy,
  output logic                      done,
  output logic [idx_w(NUM_REQ)-1:0] done_id,
  output logic [2*WIDTH-1:0]        pixel_count
`ifdef IBIS_BLIT_SCHED_ABORT_EN
  ,
  input  logic                      abort,
  output logic                      aborted
`endif
);

  localparam int IW = idx_w(NUM_REQ);
  localparam logic [WIDTH:0] XM = (WIDTH+1)'(X_MAX);
  localparam logic [WIDTH:0] YM = (WIDTH+1)'(Y_MAX);
  localparam logic [7:0] DRAIN_LAST = 8'(PIPE_DEPTH - 2);

  sched_state_e state;
  blit_desc_t   cur;
  logic [IW-1:0] cur_id;
  logic [IW-1:0] gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [WIDTH:0] sum_x, sum_y;
  logic [WIDTH:0] ex, ey, wx, wy;
  logic [WIDTH:0] ex_q, ey_q;
  logic [WIDTH:0] x_nxt, y_nxt;
  logic [7:0] drain_cnt;
  logic en_q;
  logic abrt_q;
  logic idle;
  logic adv;
  logic abort_now;
  logic unused_ok;

  assign idle = (state == S_IDLE);
  assign adv  = idle && (|req.req_valid);
  assign req.req_ready = idle ? gnt : '0;

  ibis_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .req     (req.req_valid),
    .advance (adv),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef IBIS_BLIT_SCHED_ABORT_EN
  assign abort_now = abort;
  assign aborted   = done & abrt_q;
  assign unused_ok = blt_out_valid;
`else
  assign abort_now = 1'b0;
  assign unused_ok = blt_out_valid ^ abrt_q;
`endif

  // Abort squashes the pixel of the cycle it arrives in.
  assign blt_enable = en_q & ~abort_now;

  // Clip in WIDTH+1 bits so dst+size never wraps.
  assign sum_x = {1'b0, cur.dst_x} + {1'b0, cur.width};
  assign sum_y = {1'b0, cur.dst_y} + {1'b0, cur.height};
  assign ex = (sum_x > XM) ? XM : sum_x;
  assign ey = (sum_y > YM) ? YM : sum_y;
  assign wx = (ex > {1'b0, cur.dst_x}) ?
              ex - {1'b0, cur.dst_x} : '0;
  assign wy = (ey > {1'b0, cur.dst_y}) ?
              ey - {1'b0, cur.dst_y} : '0;

  assign x_nxt = {1'b0, blt_x} + 1'b1;
  assign y_nxt = {1'b0, blt_y} + 1'b1;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      cur         <= '0;
      cur_id      <= '0;
      ex_q        <= '0;
      ey_q        <= '0;
      drain_cnt   <= '0;
      en_q        <= 1'b0;
      abrt_q      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= '0;
      pixel_count <= '0;
      blt_x       <= '0;
      blt_y       <= '0;
      blt_x_src   <= '0;
      blt_y_src   <= '0;
      blt_x_dst   <= '0;
      blt_y_dst   <= '0;
      blt_width   <= '0;
      blt_height  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (adv) begin
            cur <= blit_desc_t'(
              req.req_desc[int'(gnt_idx)*6*WIDTH +: 6*WIDTH]);
            cur_id      <= gnt_idx;
            busy        <= 1'b1;
            pixel_count <= '0;
            abrt_q      <= 1'b0;
            state       <= S_LOAD;
          end
        end
        S_LOAD: begin
          blt_x_src  <= cur.src_x;
          blt_y_src  <= cur.src_y;
          blt_x_dst  <= cur.dst_x;
          blt_y_dst  <= cur.dst_y;
          blt_width  <= wx[WIDTH-1:0];
          blt_height <= wy[WIDTH-1:0];
          blt_x      <= cur.dst_x;
          blt_y      <= cur.dst_y;
          ex_q       <= ex;
          ey_q       <= ey;
          if (abort_now) begin
            abrt_q    <= 1'b1;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else if (wx == '0 || wy == '0) begin
            done    <= 1'b1;
            done_id <= cur_id;
            state   <= S_DONE;
          end else begin
            en_q  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort_now) begin
            en_q      <= 1'b0;
            abrt_q    <= 1'b1;
            drain_cnt <= '0;
            state     <= S_DRAIN;
          end else begin
            pixel_count <= pixel_count + 1'b1;
            if (x_nxt != ex_q) begin
              blt_x <= x_nxt[WIDTH-1:0];
            end else if (y_nxt != ey_q) begin
              blt_x <= cur.dst_x;
              blt_y <= y_nxt[WIDTH-1:0];
            end else begin
              en_q      <= 1'b0;
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end
          end
        end
        // DONE itself is the last of PIPE_DEPTH idle cycles.
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            done    <= 1'b1;
            done_id <= cur_id;
            state   <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibis_blit_scheduler.sv
// Self-checking bench for ibis_blit_scheduler.
// Directed plan items plus randomized blits vs a raster/RR model.
module tb_ibis_blit_scheduler;
  import ibis_blit_pkg::*;

  localparam int W  = 10;
  localparam int NR = 2;
  localparam int XM = 640;
  localparam int YM = 480;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic blt_out_valid = 1'b0;
  logic blt_enable, busy, done;
  logic [W-1:0] blt_x, blt_y;
  logic [W-1:0] blt_x_src, blt_y_src;
  logic [W-1:0] blt_x_dst, blt_y_dst;
  logic [W-1:0] blt_width, blt_height;
  logic [0:0] done_id;
  logic [2*W-1:0] pixel_count;
`ifdef IBIS_BLIT_SCHED_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
`endif

  ibis_blit_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) rif ();

  ibis_blit_scheduler #(
    .WIDTH      (W),
    .X_MAX      (XM),
    .Y_MAX      (YM),
    .NUM_REQ    (NR),
    .PIPE_DEPTH (5)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req           (rif),
    .blt_enable    (blt_enable),
    .blt_x         (blt_x),
    .blt_y         (blt_y),
    .blt_x_src     (blt_x_src),
    .blt_y_src     (blt_y_src),
    .blt_x_dst     (blt_x_dst),
    .blt_y_dst     (blt_y_dst),
    .blt_width     (blt_width),
    .blt_height    (blt_height),
    .blt_out_valid (blt_out_valid),
    .busy          (busy),
    .done          (done),
    .done_id       (done_id),
    .pixel_count   (pixel_count)
`ifdef IBIS_BLIT_SCHED_ABORT_EN
    ,
    .abort         (abort),
    .aborted       (aborted)
`endif
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_bad = 0;
  int sx[NR], sy[NR], dx[NR], dy[NR], ww[NR], hh[NR];
  logic [NR-1:0] vmask = '0;
  int rr_ptr = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    blit_desc_t d;
    for (int r = 0; r < NR; r++) begin
      d.src_x  = W'(sx[r]);
      d.src_y  = W'(sy[r]);
      d.dst_x  = W'(dx[r]);
      d.dst_y  = W'(dy[r]);
      d.width  = W'(ww[r]);
      d.height = W'(hh[r]);
      rif.req_desc[r*6*W +: 6*W] = d;
    end
    rif.req_valid = vmask;
  endtask

  task automatic set_desc(input int r, input int a, input int b,
                          input int c, input int e,
                          input int w, input int h);
    sx[r] = a; sy[r] = b; dx[r] = c; dy[r] = e;
    ww[r] = w; hh[r] = h;
  endtask

  task automatic rand_desc(input int r);
    sx[r] = int'($urandom_range(0, 1023));
    sy[r] = int'($urandom_range(0, 1023));
    case ($urandom_range(0, 3))
      0: begin
        dx[r] = int'($urandom_range(634, 650));
        dy[r] = int'($urandom_range(0, 479));
      end
      1: begin
        dx[r] = int'($urandom_range(0, 639));
        dy[r] = int'($urandom_range(474, 490));
      end
      default: begin
        dx[r] = int'($urandom_range(0, 639));
        dy[r] = int'($urandom_range(0, 479));
      end
    endcase
    ww[r] = int'($urandom_range(0, 7));
    hh[r] = int'($urandom_range(0, 5));
  endtask

  // Called in an IDLE cycle; grant must show at once.
  task automatic serve(output int g);
    int t;
    int eg;
    t = 0;
    drive();
    #1;
    while (rif.req_ready == '0 && t < 8) begin
      @(negedge aclk);
      #1;
      t++;
    end
    eg = -1;
    for (int i = 0; i < NR; i++) begin
      int r;
      r = (rr_ptr + i) % NR;
      if (eg < 0 && vmask[r]) eg = r;
    end
    chk("grant_gap", 64'(t), 64'(0));
    chk("grant", 64'(rif.req_ready), 64'(1) << eg);
    rr_ptr = (eg + 1) % NR;
    g = (t < 8) ? eg : -1;
  endtask

  // mode: 0 drop, 1 new desc, 2 random of 0/1, 3 drop all.
  task automatic watch(input int g, input int mode, input int abt);
    int lsx, lsy, ldx, ldy, exv, eyv, cw, ch;
    int nexp, dexp, cyc, bad_pix, bad_busy, m;
    bit got_done, aexp;
    int px[$], py[$], qx[$], qy[$];
    lsx = sx[g]; lsy = sy[g]; ldx = dx[g]; ldy = dy[g];
    exv = (ldx + ww[g] < XM) ? ldx + ww[g] : XM;
    eyv = (ldy + hh[g] < YM) ? ldy + hh[g] : YM;
    cw = (exv > ldx) ? exv - ldx : 0;
    ch = (eyv > ldy) ? eyv - ldy : 0;
    for (int y = ldy; y < eyv; y++) begin
      for (int x = ldx; x < exv; x++) begin
        px.push_back(x);
        py.push_back(y);
      end
    end
    nexp = px.size();
    dexp = (nexp > 0) ? nexp + 6 : 2;
    aexp = 1'b0;
    if (abt > 0 && abt <= nexp + 1) begin
      aexp = 1'b1;
      nexp = (abt > 2) ? abt - 2 : 0;
      dexp = abt + 5;
    end
    cyc = 0;
    got_done = 1'b0;
    bad_busy = 0;
    while (!got_done && cyc < 400) begin
      @(negedge aclk);
      cyc++;
      if (cyc == 1) begin
        m = (mode == 2) ? int'($urandom_range(0, 1)) : mode;
        if (m == 1) rand_desc(g);
        else if (m == 3) vmask = '0;
        else vmask[g] = 1'b0;
        drive();
      end
`ifdef IBIS_BLIT_SCHED_ABORT_EN
      abort = (cyc == abt);
`endif
      #1;
      if (blt_enable) begin
        qx.push_back(int'(blt_x));
        qy.push_back(int'(blt_y));
      end
      if (!busy) bad_busy++;
      if (done) got_done = 1'b1;
    end
`ifdef IBIS_BLIT_SCHED_ABORT_EN
    abort = 1'b0;
    chk("aborted", 64'(aborted), 64'(aexp));
`endif
    bad_pix = 0;
    for (int i = 0; i < qx.size() && i < px.size(); i++) begin
      if (qx[i] != px[i] || qy[i] != py[i]) bad_pix++;
    end
    chk("done_seen", 64'(got_done), 64'(1));
    chk("done_cyc", 64'(cyc), 64'(dexp));
    chk("npix", 64'(qx.size()), 64'(nexp));
    chk("pix_xy", 64'(bad_pix), 64'(0));
    chk("pix_cnt", 64'(pixel_count), 64'(nexp));
    chk("done_id", 64'(done_id), 64'(g));
    chk("busy_hold", 64'(bad_busy), 64'(0));
    chk("clip_wh", 64'({blt_width, blt_height}),
        64'({W'(cw), W'(ch)}));
    chk("cfg", 64'({blt_x_src, blt_y_src, blt_x_dst, blt_y_dst}),
        64'({W'(lsx), W'(lsy), W'(ldx), W'(ldy)}));
    @(negedge aclk);
    #1;
    chk("done_pulse", 64'({done, busy}), 64'(0));
  endtask

  logic any_out;
  always_comb begin
    any_out = |{rif.req_ready, blt_enable, blt_x, blt_y,
                blt_x_src, blt_y_src, blt_x_dst, blt_y_dst,
                blt_width, blt_height, busy, done, done_id,
                pixel_count};
  end

  initial begin
    int g;
    int seen;
    rif.req_valid = '0;
    rif.req_desc  = '0;
    for (int r = 0; r < NR; r++) set_desc(r, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge aclk);
    chk("rst_outs", 64'(any_out), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_outs", 64'(any_out), 64'(0));

    set_desc(0, 5, 6, 10, 20, 3, 2);
    vmask = 2'b01;
    serve(g);
    if (g >= 0) watch(g, 0, 0);

    set_desc(1, 7, 8, 638, 479, 4, 4);
    vmask = 2'b10;
    serve(g);
    if (g >= 0) watch(g, 0, 0);

    rand_desc(0);
    rand_desc(1);
    vmask = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(g);
      chk("rr_order", 64'(g), 64'(i % 2));
      if (g >= 0) watch(g, (i == 3) ? 3 : 1, 0);
    end

    set_desc(0, 1, 2, 100, 100, 0, 7);
    vmask = 2'b01;
    serve(g);
    if (g >= 0) watch(g, 0, 0);

    set_desc(1, 3, 4, 50, 60, 8, 1);
    vmask = 2'b10;
    serve(g);
`ifdef IBIS_BLIT_SCHED_ABORT_EN
    if (g >= 0) watch(g, 0, 3);
`else
    if (g >= 0) watch(g, 0, 0);
`endif

    set_desc(0, 9, 9, 100, 100, 4, 4);
    vmask = 2'b01;
    serve(g);
    @(negedge aclk);
    vmask = '0;
    drive();
    repeat (3) @(negedge aclk);
    #1;
    chk("pre_rst_en", 64'({blt_enable, blt_x, blt_y}),
        64'({1'b1, W'(102), W'(100)}));
    aresetn = 1'b0;
    #1;
    chk("rst_mid", 64'(any_out), 64'(0));
    seen = 0;
    repeat (3) begin
      @(negedge aclk);
      if (any_out) seen++;
    end
    chk("rst_hold", 64'(seen), 64'(0));
    aresetn = 1'b1;
    rr_ptr = 0;
    rand_desc(0);
    rand_desc(1);
    vmask = 2'b11;
    serve(g);
    chk("rst_ptr", 64'(g), 64'(0));
    if (g >= 0) watch(g, 2, 0);

    for (int it = 0; it < 24; it++) begin
      for (int r = 0; r < NR; r++) begin
        if (!vmask[r] && $urandom_range(0, 1) == 1) begin
          rand_desc(r);
          vmask[r] = 1'b1;
        end
      end
      if (vmask == '0) begin
        g = int'($urandom_range(0, NR - 1));
        rand_desc(g);
        vmask[g] = 1'b1;
      end
      serve(g);
      if (g >= 0) watch(g, 2, 0);
    end

    vmask = '0;
    drive();
    repeat (3) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
